// File: rtl/ram_pkg.sv
// Shared constants and helpers for the true dual-port RAM family.
package ram_pkg;

    // Same-port read-during-write behaviour selectors
    localparam int WRITE_FIRST = 0;
    localparam int READ_FIRST  = 1;
    localparam int NO_CHANGE   = 2;

    // Byte lanes exist only when the word is a whole number of bytes
    function automatic int calc_num_be(input int data_w);
        return (data_w % 8 == 0) ? data_w / 8 : 1;
    endfunction

endpackage

// File: rtl/ram_out_stage.sv
// Per-port read output stage: valid strobe pipeline plus optional second data register.
module ram_out_stage #(
    parameter int DATA_W  = 16,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] dout,
    output logic              vld
);

    logic vld_s1;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) vld_s1 <= 1'b0;
        else     vld_s1 <= issue;
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            // Second stage loads only on a real access so dout holds between reads
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout <= '0;
                    vld  <= 1'b0;
                end else begin
                    vld <= vld_s1;
                    if (vld_s1) dout <= ram_q;
                end
            end
        end else begin : g_bypass
            assign dout = ram_q;
            assign vld  = vld_s1;
        end
    endgenerate

endmodule

// File: rtl/tdp_ram_pipelined.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write
// mode, optional output register and per-port read-valid strobes.
module tdp_ram_pipelined
    import ram_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int ADDR_W  = 7,
    parameter  int WR_MODE = WRITE_FIRST,
    parameter  int OUT_REG = 0,
    localparam int NUM_BE  = calc_num_be(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic [NUM_BE-1:0] a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_vld,
    input  logic              b_en,
    input  logic [NUM_BE-1:0] b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_vld
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int LANE_W = DATA_W / NUM_BE;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a_q, b_q;
    logic              a_issue, b_issue;
    logic [NUM_BE-1:0] b_we_eff;

    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NUM_BE-1:0] we
    );
        lane_merge = old_w;
        for (int i = 0; i < NUM_BE; i++)
            if (we[i]) lane_merge[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
    endfunction

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        a_issue  = a_en & ~((WR_MODE == NO_CHANGE) & (|a_we));
        b_issue  = b_en & ~((WR_MODE == NO_CHANGE) & (|b_we));
        b_we_eff = b_we;
        // Port A owns any lane both ports write on a shared address
        if (a_en && b_en && (a_addr == b_addr)) b_we_eff = b_we & ~a_we;
    end

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
    // Both port blocks write the shared array on the same clock, the standard TDP BRAM template.
    always @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
        end else if (a_en) begin
            for (int i = 0; i < NUM_BE; i++)
                if (a_we[i]) mem[a_addr][i*LANE_W +: LANE_W] <= a_din[i*LANE_W +: LANE_W];
            if (a_issue)
                a_q <= (WR_MODE == WRITE_FIRST) ? lane_merge(mem[a_addr], a_din, a_we)
                                                : mem[a_addr];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            b_q <= '0;
        end else if (b_en) begin
            for (int i = 0; i < NUM_BE; i++)
                if (b_we_eff[i]) mem[b_addr][i*LANE_W +: LANE_W] <= b_din[i*LANE_W +: LANE_W];
            if (b_issue)
                b_q <= (WR_MODE == WRITE_FIRST) ? lane_merge(mem[b_addr], b_din, b_we)
                                                : mem[b_addr];
        end
    end

    ram_out_stage #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_out_a (
        .clk   (clk),
        .rst   (rst),
        .issue (a_issue),
        .ram_q (a_q),
        .dout  (a_dout),
        .vld   (a_vld)
    );

    ram_out_stage #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_out_b (
        .clk   (clk),
        .rst   (rst),
        .issue (b_issue),
        .ram_q (b_q),
        .dout  (b_dout),
        .vld   (b_vld)
    );

endmodule

// File: tb/tb_tdp_ram_pipelined.sv
// Bench for tdp_ram_pipelined: four configurations share one stimulus stream and
// are compared against a word-level memory model plus a table of hand-derived vectors.
module tb_tdp_ram_pipelined;

    localparam int ND = 4;
    // dut 0: write-first, 1: read-first, 2: no-change (all latency 1); 3: write-first, latency 2
    localparam int WM   [ND] = '{0, 1, 2, 0};
    localparam int OREG [ND] = '{0, 0, 0, 1};

    logic        clk;
    logic        rst;
    logic        a_en, b_en;
    logic [1:0]  a_we, b_we;
    logic [6:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;
    logic [15:0] a_dout_w [ND];
    logic [15:0] b_dout_w [ND];
    logic        a_vld_w  [ND];
    logic        b_vld_w  [ND];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        tdp_ram_pipelined #(
            .DATA_W (16),
            .ADDR_W (7),
            .WR_MODE(WM[g]),
            .OUT_REG(OREG[g])
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .a_en  (a_en),
            .a_we  (a_we),
            .a_addr(a_addr),
            .a_din (a_din),
            .a_dout(a_dout_w[g]),
            .a_vld (a_vld_w[g]),
            .b_en  (b_en),
            .b_we  (b_we),
            .b_addr(b_addr),
            .b_din (b_din),
            .b_dout(b_dout_w[g]),
            .b_vld (b_vld_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        v;
        logic        x;
        logic [15:0] d;
    } rd_t;

    logic [15:0] mm   [128];
    bit          mk   [128];
    rd_t         pend [ND][2];
    logic [15:0] e_dout [ND][2];
    logic        e_vld  [ND][2];
    logic        e_x    [ND][2];

    task automatic model_step();
        logic        en  [2];
        logic [1:0]  we  [2];
        logic [6:0]  ad  [2];
        logic [15:0] di  [2];
        logic [15:0] old [2];
        bit          oldk[2];
        en[0] = a_en; we[0] = a_we; ad[0] = a_addr; di[0] = a_din;
        en[1] = b_en; we[1] = b_we; ad[1] = b_addr; di[1] = b_din;
        for (int p = 0; p < 2; p++) begin
            old[p]  = mm[ad[p]];
            oldk[p] = mk[ad[p]];
        end
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < 2; p++) begin
                logic        wr, hit, dx;
                logic [15:0] data;
                if (rst) begin
                    e_dout[d][p] = 16'h0;
                    e_vld[d][p]  = 1'b0;
                    e_x[d][p]    = 1'b0;
                    pend[d][p]   = '{1'b0, 1'b0, 16'h0};
                end else begin
                    wr   = |we[p];
                    hit  = en[p] && !(wr && WM[d] == 2);
                    data = old[p];
                    dx   = !oldk[p];
                    if (wr && WM[d] == 0) begin
                        for (int l = 0; l < 2; l++)
                            if (we[p][l]) data[8*l +: 8] = di[p][8*l +: 8];
                        dx = !oldk[p] && (we[p] != 2'b11);
                    end
                    if (OREG[d] == 0) begin
                        e_vld[d][p] = hit;
                        if (hit) begin
                            e_dout[d][p] = data;
                            e_x[d][p]    = dx;
                        end
                    end else begin
                        e_vld[d][p] = pend[d][p].v;
                        if (pend[d][p].v) begin
                            e_dout[d][p] = pend[d][p].d;
                            e_x[d][p]    = pend[d][p].x;
                        end
                        pend[d][p] = '{hit, dx, data};
                    end
                end
            end
        end
        if (!rst) begin
            // apply B first so A's lanes override on a shared address
            for (int p = 1; p >= 0; p--) begin
                if (en[p]) begin
                    for (int l = 0; l < 2; l++)
                        if (we[p][l]) mm[ad[p]][8*l +: 8] = di[p][8*l +: 8];
                    if (we[p] == 2'b11) mk[ad[p]] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got vld/dout=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [16:0] dut_out(input int d, input int p);
        return (p == 0) ? {a_vld_w[d], a_dout_w[d]} : {b_vld_w[d], b_dout_w[d]};
    endfunction

    task automatic compare_all(input string tag);
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < 2; p++) begin
                logic [16:0] got;
                got = dut_out(d, p);
                if (e_x[d][p])
                    check($sformatf("%s d%0d p%0d vld", tag, d, p), {got[16], 16'h0}, {e_vld[d][p], 16'h0});
                else
                    check($sformatf("%s d%0d p%0d", tag, d, p), got, {e_vld[d][p], e_dout[d][p]});
            end
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        a_en;
        logic [1:0]  a_we;
        logic [6:0]  a_addr;
        logic [15:0] a_din;
        logic        b_en;
        logic [1:0]  b_we;
        logic [6:0]  b_addr;
        logic [15:0] b_din;
        int          c0_dut;
        int          c0_port;
        logic [15:0] c0_dout;
        logic        c0_vld;
        int          c1_dut;
        int          c1_port;
        logic [15:0] c1_dout;
        logic        c1_vld;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t vin(input logic r, input logic ae, input logic [1:0] awe,
                                 input logic [6:0] aad, input logic [15:0] adi,
                                 input logic be, input logic [1:0] bwe,
                                 input logic [6:0] bad, input logic [15:0] bdi);
        vec_t v;
        v.rst = r;
        v.a_en = ae; v.a_we = awe; v.a_addr = aad; v.a_din = adi;
        v.b_en = be; v.b_we = bwe; v.b_addr = bad; v.b_din = bdi;
        v.c0_dut = -1; v.c0_port = 0; v.c0_dout = 16'h0; v.c0_vld = 1'b0;
        v.c1_dut = -1; v.c1_port = 0; v.c1_dout = 16'h0; v.c1_vld = 1'b0;
        return v;
    endfunction

    function automatic vec_t vck(input vec_t vi, input int slot, input int d, input int p,
                                 input logic [15:0] dout, input logic vld);
        vec_t v;
        v = vi;
        if (slot == 0) begin
            v.c0_dut = d; v.c0_port = p; v.c0_dout = dout; v.c0_vld = vld;
        end else begin
            v.c1_dut = d; v.c1_port = p; v.c1_dout = dout; v.c1_vld = vld;
        end
        return v;
    endfunction

    function automatic vec_t idle();
        return vin(1'b0, 1'b0, 2'b00, 7'h00, 16'h0, 1'b0, 2'b00, 7'h00, 16'h0);
    endfunction

    function automatic vec_t ard(input logic [6:0] ad);
        return vin(1'b0, 1'b1, 2'b00, ad, 16'h0, 1'b0, 2'b00, 7'h00, 16'h0);
    endfunction

    function automatic vec_t awr(input logic [6:0] ad, input logic [1:0] we, input logic [15:0] di);
        return vin(1'b0, 1'b1, we, ad, di, 1'b0, 2'b00, 7'h00, 16'h0);
    endfunction

    task automatic apply(input vec_t v);
        rst = v.rst;
        a_en = v.a_en; a_we = v.a_we; a_addr = v.a_addr; a_din = v.a_din;
        b_en = v.b_en; b_we = v.b_we; b_addr = v.b_addr; b_din = v.b_din;
    endtask

    initial begin
        // Preload leaves mem[i] = 0x10 + i, so mem[0x10]=0x20, mem[0x20]=0x30, mem[0x30]=0x40
        vq.push_back(vck(awr(7'h05, 2'b11, 16'h1234), 0, 0, 0, 16'h1234, 1'b1));                    // 0
        vq.push_back(vck(idle(), 0, 3, 0, 16'h1234, 1'b1));                                          // 1
        vq.push_back(vck(vck(vin(1'b0, 1'b0, 2'b00, 7'h00, 16'h0, 1'b1, 2'b00, 7'h05, 16'h0),
                             0, 0, 1, 16'h1234, 1'b1), 1, 0, 0, 16'h1234, 1'b0));                    // 2
        vq.push_back(vck(awr(7'h10, 2'b11, 16'hAAAA), 0, 1, 0, 16'h0020, 1'b1));                    // 3
        vq.push_back(vck(vck(awr(7'h10, 2'b01, 16'h5555), 0, 0, 0, 16'hAA55, 1'b1),
                         1, 1, 0, 16'hAAAA, 1'b1));                                                  // 4
        vq.push_back(vck(vck(ard(7'h10), 0, 0, 0, 16'hAA55, 1'b1), 1, 1, 0, 16'hAA55, 1'b1));        // 5
        vq.push_back(vck(awr(7'h30, 2'b11, 16'h1111), 0, 2, 0, 16'hAA55, 1'b0));                    // 6
        vq.push_back(vck(ard(7'h30), 0, 2, 0, 16'h1111, 1'b1));                                      // 7
        vq.push_back(vck(vck(awr(7'h30, 2'b11, 16'h7777), 0, 2, 0, 16'h1111, 1'b0),
                         1, 0, 0, 16'h7777, 1'b1));                                                  // 8
        vq.push_back(vck(awr(7'h20, 2'b11, 16'h0000), 0, 1, 0, 16'h0030, 1'b1));                    // 9
        vq.push_back(vck(vck(vin(1'b0, 1'b1, 2'b01, 7'h20, 16'h00FF, 1'b1, 2'b11, 7'h20, 16'hABCD),
                             0, 0, 0, 16'h00FF, 1'b1), 1, 1, 1, 16'h0000, 1'b1));                    // 10
        vq.push_back(vck(vck(vin(1'b0, 1'b1, 2'b00, 7'h20, 16'h0, 1'b1, 2'b00, 7'h20, 16'h0),
                             0, 0, 0, 16'hABFF, 1'b1), 1, 0, 1, 16'hABFF, 1'b1));                    // 11
        vq.push_back(vck(vck(vin(1'b0, 1'b1, 2'b11, 7'h20, 16'h9999, 1'b1, 2'b00, 7'h20, 16'h0),
                             0, 0, 1, 16'hABFF, 1'b1), 1, 0, 0, 16'h9999, 1'b1));                    // 12
        vq.push_back(vck(vck(vin(1'b0, 1'b0, 2'b00, 7'h00, 16'h0, 1'b1, 2'b00, 7'h20, 16'h0),
                             0, 2, 1, 16'h9999, 1'b1), 1, 0, 0, 16'h9999, 1'b0));                    // 13
        vq.push_back(vck(vck(ard(7'h00), 0, 3, 0, 16'h9999, 1'b0), 1, 0, 0, 16'h0010, 1'b1));        // 14
        vq.push_back(vck(vck(ard(7'h01), 0, 3, 0, 16'h0010, 1'b1), 1, 0, 0, 16'h0011, 1'b1));        // 15
        vq.push_back(vck(vck(ard(7'h02), 0, 3, 0, 16'h0011, 1'b1), 1, 0, 0, 16'h0012, 1'b1));        // 16
        vq.push_back(vck(vck(ard(7'h03), 0, 3, 0, 16'h0012, 1'b1), 1, 0, 0, 16'h0013, 1'b1));        // 17
        vq.push_back(vck(vck(idle(), 0, 3, 0, 16'h0013, 1'b1), 1, 0, 0, 16'h0013, 1'b0));            // 18
        vq.push_back(vck(idle(), 0, 3, 0, 16'h0013, 1'b0));                                          // 19
        vq.push_back(vck(vck(ard(7'h05), 0, 0, 0, 16'h1234, 1'b1), 1, 3, 0, 16'h0013, 1'b0));        // 20
        vq.push_back(vck(vck(vin(1'b1, 1'b1, 2'b11, 7'h05, 16'h4321, 1'b0, 2'b00, 7'h00, 16'h0),
                             0, 3, 0, 16'h0000, 1'b0), 1, 0, 0, 16'h0000, 1'b0));                    // 21
        vq.push_back(vck(vck(idle(), 0, 3, 0, 16'h0000, 1'b0), 1, 3, 1, 16'h0000, 1'b0));            // 22
        vq.push_back(vck(vck(ard(7'h05), 0, 0, 0, 16'h1234, 1'b1), 1, 1, 0, 16'h1234, 1'b1));        // 23
        vq.push_back(vck(idle(), 0, 3, 0, 16'h1234, 1'b1));                                          // 24

        for (int d = 0; d < ND; d++)
            for (int p = 0; p < 2; p++) begin
                e_dout[d][p] = 16'h0; e_vld[d][p] = 1'b0; e_x[d][p] = 1'b0;
                pend[d][p] = '{1'b0, 1'b0, 16'h0};
            end
        for (int i = 0; i < 128; i++) begin
            mm[i] = 16'h0; mk[i] = 1'b0;
        end

        // NOTE: the bench drives DUT inputs with blocking assignments away from the clock edge.
        apply(idle());
        rst = 1'b1;
        tick("reset");
        tick("reset");
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            apply(vin(1'b0, 1'b1, 2'b11, 7'(i), 16'(16'h10 + i),
                      1'b1, 2'b11, 7'(i + 64), 16'(16'h10 + i + 64)));
            tick("preload");
        end

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i]);
            tick($sformatf("vec%0d", i));
            if (vq[i].c0_dut >= 0)
                check($sformatf("vec%0d.c0", i), dut_out(vq[i].c0_dut, vq[i].c0_port),
                      {vq[i].c0_vld, vq[i].c0_dout});
            if (vq[i].c1_dut >= 0)
                check($sformatf("vec%0d.c1", i), dut_out(vq[i].c1_dut, vq[i].c1_port),
                      {vq[i].c1_vld, vq[i].c1_dout});
        end

        // Random traffic on a narrow address window to provoke collisions
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 59) == 0);
            a_en   = ($urandom_range(0, 3) != 0);
            a_we   = 2'($urandom_range(0, 3));
            a_addr = 7'($urandom_range(0, 15));
            a_din  = 16'($urandom);
            b_en   = ($urandom_range(0, 3) != 0);
            b_we   = 2'($urandom_range(0, 3));
            b_addr = 7'($urandom_range(0, 15));
            b_din  = 16'($urandom);
            if (a_en && b_en && a_addr == b_addr && (|a_we) && (|b_we)) b_we = 2'b00;
            tick($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
